// File: rtl/alu_test_sequencer.sv
// Programmable ALU/register-file test sequencer: replays a loadable step table, reads back each
// destination register and checks it. Optional ALUSEQ_SINGLE_STEP_EN adds a step_i port and a HOLD state.
module alu_test_sequencer #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int ALUOP_W  = 8,
    parameter  int STEPS    = 16,
    parameter  int FCNT_W   = 8,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int SW       = $clog2(STEPS),
    localparam int ENTRY_W  = 4 + ALUOP_W + 3*RW + 2*DATA_W
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
`ifdef ALUSEQ_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    input  logic                prog_we_i,
    input  logic [SW-1:0]       prog_addr_i,
    input  logic [ENTRY_W-1:0]  prog_data_i,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic [NUM_REGS-1:0] reg_en_o,
    output logic [NUM_REGS-1:0] buf_a_o,
    output logic [NUM_REGS-1:0] buf_b_o,
    output logic [DATA_W-1:0]   imm_o,
    output logic                imm_en_o,
    output logic                cin_o,
    output logic [RW-1:0]       reg_read_num_o,
    input  logic [DATA_W-1:0]   reg_read_data_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [FCNT_W-1:0]   fail_count_o,
    output logic [SW-1:0]       first_fail_o
);
    localparam int SRCB_L = 2*DATA_W;
    localparam int SRCA_L = SRCB_L + RW;
    localparam int DST_L  = SRCA_L + RW;
    localparam int OP_L   = DST_L + RW;
    localparam int IMMEN  = OP_L + ALUOP_W;

    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, WAIT, CHECK, DONE
`ifdef ALUSEQ_SINGLE_STEP_EN
        , HOLD
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [FCNT_W-1:0]   fail_q, fail_d;
    logic [SW-1:0]       ff_q, ff_d;
    logic [ENTRY_W-1:0]  entry_q;
    logic [ENTRY_W-1:0]  mem_q [STEPS];

    logic [DATA_W-1:0]   e_exp, e_imm;
    logic [RW-1:0]       e_srcb, e_srca, e_dst;
    logic [ALUOP_W-1:0]  e_op;
    logic                e_immen, e_cin, e_chk, e_last;
    logic [NUM_REGS-1:0] dst_oh, srca_oh, srcb_oh;
    logic                last_step;

    assign e_exp   = entry_q[DATA_W-1:0];
    assign e_imm   = entry_q[SRCB_L-1:DATA_W];
    assign e_srcb  = entry_q[SRCA_L-1:SRCB_L];
    assign e_srca  = entry_q[DST_L-1:SRCA_L];
    assign e_dst   = entry_q[OP_L-1:DST_L];
    assign e_op    = entry_q[IMMEN-1:OP_L];
    assign e_immen = entry_q[IMMEN];
    assign e_cin   = entry_q[IMMEN+1];
    assign e_chk   = entry_q[IMMEN+2];
    assign e_last  = entry_q[IMMEN+3];

    // Out-of-range register indices simply match no decoder output.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
        assign dst_oh[g]  = (e_dst  == RW'(g));
        assign srca_oh[g] = (e_srca == RW'(g));
        assign srcb_oh[g] = (e_srcb == RW'(g));
    end

    assign last_step = e_last || (step_q == SW'(STEPS-1));

    assign busy_o       = (state_q != IDLE) && (state_q != DONE);
    assign done_o       = (state_q == DONE);
    assign pass_o       = done_o && (fail_q == '0);
    assign fail_count_o = fail_q;
    assign first_fail_o = ff_q;

    always_ff @(posedge clk_i) begin
        if (prog_we_i && !busy_o && (int'(prog_addr_i) < STEPS))
            mem_q[prog_addr_i] <= prog_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            step_q  <= '0;
            fail_q  <= '0;
            ff_q    <= '0;
            entry_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            fail_q  <= fail_d;
            ff_q    <= ff_d;
            if (state_q == FETCH)
                entry_q <= mem_q[step_q];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fail_d  = fail_q;
        ff_d    = ff_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = FETCH;
                    step_d  = '0;
                    fail_d  = '0;
                    ff_d    = '0;
                end
            end
            FETCH: state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  state_d = CHECK;
            CHECK: begin
                if (e_chk && (reg_read_data_i != e_exp)) begin
                    if (fail_q == '0)
                        ff_d = step_q;
                    if (fail_q != '1)
                        fail_d = fail_q + 1'b1;
                end
`ifdef ALUSEQ_SINGLE_STEP_EN
                state_d = HOLD;
            end
            HOLD: begin
                if (step_i) begin
                    if (last_step) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        step_d  = step_q + 1'b1;
                    end
                end
`else
                if (last_step) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                    step_d  = step_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_op_o       = '0;
        reg_en_o       = '0;
        buf_a_o        = '0;
        buf_b_o        = '0;
        imm_o          = '0;
        imm_en_o       = 1'b0;
        cin_o          = 1'b0;
        reg_read_num_o = '0;
        if (state_q == ISSUE) begin
            alu_op_o = e_op;
            reg_en_o = dst_oh;
            buf_a_o  = srca_oh;
            buf_b_o  = e_immen ? '0 : srcb_oh;
            imm_o    = e_imm;
            imm_en_o = e_immen;
            cin_o    = e_cin;
        end
        if (state_q == WAIT || state_q == CHECK)
            reg_read_num_o = e_dst;
    end
endmodule

// File: tb/tb_alu_test_sequencer.sv
// Directed bench for alu_test_sequencer with a behavioural ALU/register-file model.
// A second instance with FCNT_W=2 and readback tied to zero exercises fail-counter saturation.
module tb_alu_test_sequencer;
    logic        clk_i = 0;
    logic        reset_i = 1;
    logic        start_i = 0, start_s = 0;
    logic        step_r = 0;
    logic        prog_we = 0, prog_we_s = 0;
    logic [3:0]  prog_addr = 0;
    logic [55:0] prog_data = 0;
    logic [7:0]  alu_op;
    logic [15:0] reg_en, buf_a, buf_b, imm, rrd;
    logic        imm_en, cin, busy, done, pass;
    logic [3:0]  rnum, ffail;
    logic [7:0]  fcnt;

    logic [7:0]  s_op;
    logic [15:0] s_en, s_ba, s_bb, s_imm;
    logic        s_ie, s_cin, s_busy, s_done, s_pass;
    logic [3:0]  s_rn, s_ff;
    logic [1:0]  s_fc;

    int n_cmp = 0, n_bad = 0;
    logic [15:0] regs [16] = '{default: 16'h0};
    logic [15:0] log_q [8];
    int log_n = 0;

    always #5 clk_i = ~clk_i;

    alu_test_sequencer dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i),
`ifdef ALUSEQ_SINGLE_STEP_EN
        .step_i(step_r),
`endif
        .prog_we_i(prog_we), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .alu_op_o(alu_op), .reg_en_o(reg_en), .buf_a_o(buf_a), .buf_b_o(buf_b),
        .imm_o(imm), .imm_en_o(imm_en), .cin_o(cin), .reg_read_num_o(rnum),
        .reg_read_data_i(rrd), .busy_o(busy), .done_o(done), .pass_o(pass),
        .fail_count_o(fcnt), .first_fail_o(ffail));

    alu_test_sequencer #(.FCNT_W(2)) u_sat (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_s),
`ifdef ALUSEQ_SINGLE_STEP_EN
        .step_i(step_r),
`endif
        .prog_we_i(prog_we_s), .prog_addr_i(prog_addr), .prog_data_i(prog_data),
        .alu_op_o(s_op), .reg_en_o(s_en), .buf_a_o(s_ba), .buf_b_o(s_bb),
        .imm_o(s_imm), .imm_en_o(s_ie), .cin_o(s_cin), .reg_read_num_o(s_rn),
        .reg_read_data_i(16'h0000), .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass),
        .fail_count_o(s_fc), .first_fail_o(s_ff));

    function automatic int oh2idx(input logic [15:0] oh);
        for (int i = 0; i < 16; i++)
            if (oh[i]) return i;
        return 0;
    endfunction

    // Op 0 passes B through; op 1 is A+B+cin.
    always @(posedge clk_i) begin
        logic [15:0] a, b;
        a = regs[oh2idx(buf_a)];
        b = imm_en ? imm : regs[oh2idx(buf_b)];
        if (reg_en != 0)
            regs[oh2idx(reg_en)] <= (alu_op == 8'd1) ? a + b + {15'd0, cin} : b;
    end
    assign rrd = regs[rnum];

    always @(negedge clk_i) begin
        if (start_i) log_n = 0;
        else if (reg_en != 0 && log_n < 8) begin
            log_q[log_n] = reg_en;
            log_n++;
        end
    end

    function automatic logic [55:0] ent(input bit last, input bit ck, input bit ci, input bit ie,
            input logic [7:0] op, input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb,
            input logic [15:0] im, input logic [15:0] ex);
        return {last, ck, ci, ie, op, dst, sa, sb, im, ex};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [55:0] d);
        prog_addr = a; prog_data = d; prog_we = 1;
        tick();
        prog_we = 0;
    endtask

    task automatic wr_s(input logic [3:0] a, input logic [55:0] d);
        prog_addr = a; prog_data = d; prog_we_s = 1;
        tick();
        prog_we_s = 0;
    endtask

    task automatic go();
        start_i = 1;
        tick();
        start_i = 0;
    endtask

    task automatic load_prog(input logic [15:0] exp2);
        wr(0, ent(0, 1, 0, 1, 8'd0, 4'd1, 4'd0, 4'd0, 16'd5, 16'd5));
        wr(1, ent(0, 1, 0, 1, 8'd0, 4'd2, 4'd0, 4'd0, 16'd7, 16'd7));
        wr(2, ent(1, 1, 0, 0, 8'd1, 4'd3, 4'd1, 4'd2, 16'd0, exp2));
    endtask

    initial begin
        tick(2);
        reset_i = 0;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_regen", reg_en, 0);
        chk("rst_fcnt", fcnt, 0);
        chk("rst_ffail", ffail, 0);
        load_prog(16'd12);
`ifdef ALUSEQ_SINGLE_STEP_EN
        go();
        for (int k = 0; k < 3; k++) begin
            tick(4);
            chk("ss_hold_busy", busy, 1);
            chk("ss_hold_done", done, 0);
            chk("ss_hold_regen", reg_en, 0);
            if (k == 1) go();
            else tick();
            tick(2);
            chk("ss_still_hold", busy, 1);
            step_r = 1;
            tick();
            step_r = 0;
        end
        chk("ss_done", done, 1);
        chk("ss_pass", pass, 1);
`else
        // Basic 3-step run, ISSUE at t=1,5,9, done at t=12.
        go();
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) begin
                chk("iss0_imm", imm, 16'd5);
                chk("iss0_imm_en", imm_en, 1);
                chk("iss0_bufb", buf_b, 0);
            end
            if (t == 2) begin
                chk("wait0_rnum", rnum, 1);
                chk("wait0_regen", reg_en, 0);
            end
            if (t == 9) begin
                chk("iss2_bufa", buf_a, 16'h0002);
                chk("iss2_bufb", buf_b, 16'h0004);
                chk("iss2_op", alu_op, 1);
            end
            if (t == 11) chk("run1_early_done", done, 0);
        end
        chk("run1_done", done, 1);
        chk("run1_pass", pass, 1);
        chk("run1_fcnt", fcnt, 0);
        chk("run1_busy", busy, 0);
        chk("run1_nlog", log_n, 3);
        chk("run1_en0", log_q[0], 16'h0002);
        chk("run1_en1", log_q[1], 16'h0004);
        chk("run1_en2", log_q[2], 16'h0008);
        tick(3);
        chk("run1_done_held", done, 1);

        // Wrong expected value on step 2.
        wr(2, ent(1, 1, 0, 0, 8'd1, 4'd3, 4'd1, 4'd2, 16'd0, 16'd13));
        go();
        tick(12);
        chk("bad_done", done, 1);
        chk("bad_pass", pass, 0);
        chk("bad_fcnt", fcnt, 1);
        chk("bad_ffail", ffail, 2);
        load_prog(16'd12);

        // Reset during ISSUE of step 1.
        go();
        tick(5);
        chk("mid_regen", reg_en, 16'h0004);
        reset_i = 1;
        tick();
        reset_i = 0;
        chk("mrst_busy", busy, 0);
        chk("mrst_regen", reg_en, 0);
        chk("mrst_op", alu_op, 0);
        chk("mrst_imm", imm, 0);
        chk("mrst_done", done, 0);
        go();
        tick(12);
        chk("rerun_done", done, 1);
        chk("rerun_pass", pass, 1);

        // Write and start while busy are both ignored.
        go();
        tick(2);
        start_i = 1;
        wr(0, ent(1, 1, 0, 1, 8'd0, 4'd1, 4'd0, 4'd0, 16'hDEAD, 16'h0BAD));
        start_i = 0;
        tick(8);
        chk("ign_early_done", done, 0);
        tick();
        chk("ign_done", done, 1);
        chk("ign_pass", pass, 1);
        go();
        tick(12);
        chk("ign_rerun_pass", pass, 1);
        chk("ign_rerun_fcnt", fcnt, 0);

        // Full 16-entry table with no last bit.
        for (int i = 0; i < 16; i++)
            wr(4'(i), ent(0, 1, 0, 1, 8'd0, 4'(i), 4'd0, 4'd0, 16'(16'h100 + i), 16'(16'h100 + i)));
        go();
        tick(63);
        chk("full_early_done", done, 0);
        chk("full_busy", busy, 1);
        tick();
        chk("full_done", done, 1);
        chk("full_pass", pass, 1);
        chk("full_ffail", ffail, 0);

        // Saturation: step 0 passes, steps 1..5 fail.
        wr_s(0, ent(0, 1, 0, 1, 8'd0, 4'd1, 4'd0, 4'd0, 16'd0, 16'd0));
        for (int i = 1; i <= 5; i++)
            wr_s(4'(i), ent(i == 5, 1, 0, 1, 8'd0, 4'd1, 4'd0, 4'd0, 16'd1, 16'd1));
        start_s = 1;
        tick();
        start_s = 0;
        tick(23);
        chk("sat_early_done", s_done, 0);
        tick();
        chk("sat_done", s_done, 1);
        chk("sat_fcnt", s_fc, 3);
        chk("sat_ffail", s_ff, 1);
        chk("sat_pass", s_pass, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
